// File: rtl/receipt_generator_if.sv
// Receipt generator handshake bundle.
// Retire side:  instr_valid/instr_ready with opcode and operand.
// Receipt side: rcpt_valid/rcpt_ready with the head receipt fields
//               {pre_mu, post_mu, opcode, operand, seq}.
// master = retire stage + receipt consumer (testbench/system side)
// slave  = receipt_generator
interface receipt_generator_if #(
    parameter int SEQ_WIDTH = 16
);
    logic                 instr_valid;
    logic                 instr_ready;
    logic [7:0]           instr_opcode;
    logic [31:0]          instr_operand;
    logic                 rcpt_valid;
    logic                 rcpt_ready;
    logic [31:0]          rcpt_pre_mu;
    logic [31:0]          rcpt_post_mu;
    logic [7:0]           rcpt_opcode;
    logic [31:0]          rcpt_operand;
    logic [SEQ_WIDTH-1:0] rcpt_seq;

    modport master (
        output instr_valid, instr_opcode, instr_operand, rcpt_ready,
        input  instr_ready, rcpt_valid, rcpt_pre_mu, rcpt_post_mu,
               rcpt_opcode, rcpt_operand, rcpt_seq
    );

    modport slave (
        input  instr_valid, instr_opcode, instr_operand, rcpt_ready,
        output instr_ready, rcpt_valid, rcpt_pre_mu, rcpt_post_mu,
               rcpt_opcode, rcpt_operand, rcpt_seq
    );
endinterface

// File: rtl/receipt_generator.sv
// Receipt generator: turns retired instructions into chained mu-receipts
// (post_mu = pre_mu + cost, pre of each receipt = post of the previous one)
// and queues them in a show-ahead FIFO so downstream backpressure stalls
// retirement.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   mu_init_valid/
//   mu_init_value     load starting mu and (re)start generation
//   bus (slave)       instruction in / receipt out handshakes
//   running_mu        accumulated mu
//   state             0=IDLE 1=RUN 2=HALTED 3=FAULT
//   fault_code        0=none 3=unknown opcode 4=mu overflow (sticky)
//   fifo_count        occupied receipt FIFO entries
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | after reset, waiting for mu_init
// RUN     | accepting instructions while the FIFO has room
// HALTED  | HALT receipt issued; queue drains, waiting for mu_init
// FAULT   | unknown opcode or overflow; queue drains, waiting for mu_init
module receipt_generator #(
    parameter int FIFO_DEPTH = 4,
    parameter int SEQ_WIDTH  = 16,
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mu_init_valid,
    input  logic [31:0]            mu_init_value,
    receipt_generator_if.slave     bus,
    output logic [31:0]            running_mu,
    output logic [1:0]             state,
    output logic [31:0]            fault_code,
    output logic [CNT_W-1:0]       fifo_count
);
    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0]          pre_mu;
        logic [31:0]          post_mu;
        logic [7:0]           opcode;
        logic [31:0]          operand;
        logic [SEQ_WIDTH-1:0] seq;
    } rcpt_t;

    state_t               state_q, state_d;
    logic [31:0]          mu_q;
    logic [31:0]          fault_q;
    logic [SEQ_WIDTH-1:0] seq_q;
    logic [CNT_W-1:0]     count_q;
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    rcpt_t                mem [FIFO_DEPTH];
    rcpt_t                head;

    logic        op_arith, op_halt, op_known;
    logic [31:0] cost;
    logic [32:0] sum;
    logic        accept, overflow, push, pop, init_ok;

    // Cost decode: 0x00-0x10 cost the operand, HALT costs nothing.
    always_comb begin
        op_arith = (bus.instr_opcode <= 8'h10);
        op_halt  = (bus.instr_opcode == 8'hFF);
        op_known = op_arith || op_halt;
        cost     = op_arith ? bus.instr_operand : 32'd0;
        sum      = {1'b0, mu_q} + {1'b0, cost};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (accept) begin
                    if (!op_known || overflow) state_d = S_FAULT;
                    else if (op_halt)          state_d = S_HALTED;
                end
            end
            default: begin
                if (init_ok) state_d = S_RUN;
            end
        endcase
    end

    // Output / control logic. instr_ready looks only at the registered
    // count, so a pop in the same cycle never frees a slot early.
    always_comb begin
        bus.instr_ready = (state_q == S_RUN) && (count_q < DEPTH_C);
        accept          = bus.instr_valid && bus.instr_ready;
        overflow        = sum[32];
        push            = accept && op_known && !overflow;
        pop             = (count_q != '0) && bus.rcpt_ready;
        init_ok         = mu_init_valid && (state_q != S_RUN) && (count_q == '0);
    end

    // Accumulator, sequence, fault and FIFO bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mu_q    <= '0;
            fault_q <= '0;
            seq_q   <= '0;
            count_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            if (init_ok) begin
                mu_q    <= mu_init_value;
                seq_q   <= '0;
                fault_q <= '0;
            end else if (accept) begin
                if (!op_known) begin
                    fault_q <= 32'd3;
                end else if (overflow) begin
                    fault_q <= 32'd4;
                end else begin
                    mu_q  <= sum[31:0];
                    seq_q <= seq_q + SEQ_WIDTH'(1);
                end
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the read side is gated by the count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pre_mu:  mu_q,
                             post_mu: sum[31:0],
                             opcode:  bus.instr_opcode,
                             operand: bus.instr_operand,
                             seq:     seq_q};
        end
    end

    always_comb begin
        head              = mem[rd_ptr];
        bus.rcpt_valid    = (count_q != '0);
        bus.rcpt_pre_mu   = bus.rcpt_valid ? head.pre_mu  : '0;
        bus.rcpt_post_mu  = bus.rcpt_valid ? head.post_mu : '0;
        bus.rcpt_opcode   = bus.rcpt_valid ? head.opcode  : '0;
        bus.rcpt_operand  = bus.rcpt_valid ? head.operand : '0;
        bus.rcpt_seq      = bus.rcpt_valid ? head.seq     : '0;
    end

    assign running_mu = mu_q;
    assign state      = state_q;
    assign fault_code = fault_q;
    assign fifo_count = count_q;
endmodule

// File: doc/receipt_generator.md
Name: receipt_generator

Overview:
- Producer end of the receipt protocol: accepts retired instructions (opcode, operand) and emits μ-receipts {pre_mu, post_mu, opcode, operand, seq}.
- Each receipt satisfies post_mu = pre_mu + instruction_cost, and consecutive receipts chain with pre_{n+1} = post_n.
- Sits between the core's retire stage and the downstream receipt integrity checker or log.
- Buffers receipts in a show-ahead FIFO so downstream backpressure stalls retirement cleanly.

Parameters:
- FIFO_DEPTH, 4, receipt FIFO entries; power of two, ≥2.
- SEQ_WIDTH, 16, width of the receipt sequence counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- mu_init_valid  in  1  load the starting μ value and (re)start generation
- mu_init_value  in  32  starting μ value
- instr_valid  in  1  retired instruction present
- instr_ready  out  1  generator accepts instruction this cycle
- instr_opcode  in  8  instruction opcode
- instr_operand  in  32  instruction operand
- rcpt_valid  out  1  receipt at FIFO head
- rcpt_ready  in  1  downstream consumes receipt
- rcpt_pre_mu  out  32  receipt pre-state μ
- rcpt_post_mu  out  32  receipt post-state μ
- rcpt_opcode  out  8  receipt opcode
- rcpt_operand  out  32  receipt operand
- rcpt_seq  out  SEQ_WIDTH  receipt sequence number
- running_mu  out  32  current accumulated μ
- state  out  2  0=IDLE, 1=RUN, 2=HALTED, 3=FAULT
- fault_code  out  32  0=none, 3=unknown opcode, 4=overflow
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries

Behaviour:
- Reset (asynchronous, takes effect immediately on rst=1):
  - state=IDLE; running_mu, fault_code, seq and fifo_count = 0.
  - rcpt_valid=0, instr_ready=0, all rcpt_* data = 0.
  - FIFO contents are discarded.
- Cost function (combinational):
  - Opcodes 0x00–0x10: cost = operand.
  - Opcode 0xFF (HALT): cost = 0.
  - Any other opcode is unknown.
- instr_ready = (state==RUN) && (fifo_count < FIFO_DEPTH).
  - Derived from the registered count only; a same-cycle pop does not free space.
- An instruction is accepted when instr_valid && instr_ready. sum = {1'b0,running_mu} + {1'b0,cost}, computed at 33 bits.
  - Unknown opcode: no push; running_mu unchanged; state←FAULT; fault_code←3.
  - sum[32]=1: no push; running_mu unchanged; state←FAULT; fault_code←4.
  - Otherwise: push {running_mu, sum[31:0], opcode, operand, seq}; running_mu←sum[31:0]; seq←seq+1, wrapping modulo 2^SEQ_WIDTH.
  - HALT that pushes successfully: state←HALTED after the push.
- Latency: a receipt accepted into an empty FIFO appears with rcpt_valid=1 on the next cycle.
- FIFO is show-ahead:
  - rcpt_* reflect the head entry; pop on rcpt_valid && rcpt_ready.
  - Simultaneous push and pop: count unchanged.
  - While rcpt_valid && !rcpt_ready, rcpt_* hold stable.
- Receipts are emitted strictly in acceptance order. Chain invariant on output: each rcpt_pre_mu equals the previous rcpt_post_mu since the last mu_init.
- Queued receipts continue to drain in HALTED and FAULT; no new instructions are accepted in those states.
- mu_init_valid:
  - Honoured in IDLE, HALTED or FAULT, and only when fifo_count==0.
  - Effect: running_mu←mu_init_value; seq←0; fault_code←0; state←RUN next cycle.
  - Ignored in RUN or when the FIFO is non-empty.
- fault_code is sticky until an honoured mu_init_valid or reset.

Test Plan:
1. mu_init 100. Send PNEW (0x00) operand 5, then LASSERT (0x03) operand 7. Required: receipts (pre 100, post 105, seq 0) and (105, 112, seq 1); running_mu=112.
2. FIFO_DEPTH=4, rcpt_ready=0, five back-to-back instructions. Required: four accepted; instr_ready=0 with fifo_count=4; 5th held. Raise rcpt_ready: in-order drain, 5th accepted, chain intact, data stable while stalled.
3. After two receipts, send HALT operand 99. Required: receipt with post==pre; state=HALTED; instr_ready=0; a later instr_valid produces nothing; mu_init 0 after drain → RUN with seq=0.
4. Opcode 0x20 operand 3. Required: no receipt, state=FAULT, fault_code=3, running_mu unchanged. mu_init while FIFO non-empty is ignored; once the FIFO is empty it → RUN with fault_code=0.
5. mu_init 0xFFFFFFF0, XFER (0x07) operand 0x10. Required: FAULT, fault_code=4, no receipt. Re-init 0xFFFFFFF0, then operand 0x0F. Required: receipt post=0xFFFFFFFF.
6. Assert rst mid-drain, with 3 receipts queued and rcpt_valid=1. Required: rcpt_valid, fifo_count, running_mu and state go to 0 without waiting for a clock edge; after release, no stale receipts appear.
